// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^128) reduction stage.
//   GF_M         field degree, and the width of each half of the unreduced input
//   GF_POLY_LOW  low terms of f(x) = x^128 + x^7 + x^2 + x + 1 (the x^128 term is implicit)
//   state_t      reduction FSM state encoding
package gf_pkg;

    localparam int          GF_M        = 128;
    localparam logic [127:0] GF_POLY_LOW = 128'h87;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/gf_fold_chunk.sv
// Combinational fold of CHUNK consecutive upper bits of the working value.
// Bits i_base, i_base-1, ..., i_base-CHUNK+1 are handled MSB first. Each fold
// sees the result of the one before it, so a bit set by a higher fold is still
// cleared if it falls inside the same chunk.
//   i_w     256-bit working value before this chunk
//   i_base  index of the highest bit in this chunk (always >= 128)
//   o_w     working value after the chunk's folds
module gf_fold_chunk
    import gf_pkg::*;
#(
    parameter int           CHUNK    = 8,
    parameter logic [127:0] POLY_LOW = GF_POLY_LOW
) (
    input  logic [255:0] i_w,
    input  logic [7:0]   i_base,
    output logic [255:0] o_w
);

    // Full modulus {1, POLY_LOW}, aligned so that shifting by (j-128) puts the
    // leading 1 on bit j.
    logic [255:0] w_poly;
    logic [255:0] w_acc;
    logic [7:0]   w_idx;

    assign w_poly = {127'd0, 1'b1, POLY_LOW};

    always_comb begin
        w_acc = i_w;
        w_idx = '0;
        for (int k = 0; k < CHUNK; k++) begin
            w_idx = i_base - 8'(k);
            if (w_acc[w_idx]) begin
                w_acc = w_acc ^ (w_poly << (w_idx - 8'd128));
            end
        end
    end

    assign o_w = w_acc;

endmodule

// File: rtl/gf128_reduce_seq.sv
// Sequential reduction of a 256-bit unreduced GF(2^128) product modulo f(x).
// CHUNK upper bits are folded per clock, MSB first; the 128-bit result is
// returned over a valid/ready handshake.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_c = bits 255:128, in_d = bits 127:0
//   out_valid / out_ready result handshake; out_data = {in_c,in_d} mod f(x)
// Optional build macro: GF_REDUCE_ZERO_SKIP_EN enables early exit once all
// unprocessed upper bits are zero (variable latency, identical results).
//
//   state | meaning
//   IDLE  | waiting for an operand, in_ready high
//   RUN   | folding one chunk per clock, cnt counts finished chunks
//   DONE  | result held on out_data until out_ready
module gf128_reduce_seq
    import gf_pkg::*;
#(
    parameter int           M        = GF_M,
    parameter int           CHUNK    = 8,
    parameter logic [127:0] POLY_LOW = GF_POLY_LOW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_c,
    input  logic [127:0] in_d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int N_CHUNKS = M / CHUNK;
    localparam int CNT_W    = $clog2(N_CHUNKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CHUNKS - 1);

    state_t           r_state;
    logic [255:0]     r_w;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [127:0]     r_out_data;

    logic [7:0]       w_base;
    logic [255:0]     w_folded;

    // Highest bit of the chunk folded this clock: 255 - cnt*CHUNK.
    assign w_base = 8'd255 - 8'(32'(r_cnt) * CHUNK);

    gf_fold_chunk #(
        .CHUNK    (CHUNK),
        .POLY_LOW (POLY_LOW)
    ) u_fold (
        .i_w    (r_w),
        .i_base (w_base),
        .o_w    (w_folded)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_w         <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_w        <= {in_c, in_d};
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
`ifdef GF_REDUCE_ZERO_SKIP_EN
                        if (in_c == '0) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= in_d;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_RUN;
                        end
`else
                        r_state <= ST_RUN;
`endif
                    end
                end

                ST_RUN: begin
                    r_w   <= w_folded;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_folded[127:0];
                        r_state     <= ST_DONE;
                    end
`ifdef GF_REDUCE_ZERO_SKIP_EN
                    // Bits above the processed chunks are already zero (a fold
                    // never sets bits above the one it clears), so the whole
                    // upper half being zero means nothing is left to fold.
                    else if (w_folded[255:128] == '0) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_folded[127:0];
                        r_state     <= ST_DONE;
                    end
`endif
                end

                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_gf128_reduce_seq.sv
module tb_gf128_reduce_seq;

    localparam int CHUNK   = 8;
    localparam int LAT     = 128 / CHUNK;
    localparam logic [127:0] POLY = 128'h87;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_c;
    logic [127:0] in_d;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gf128_reduce_seq #(.CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_c      (in_c),
        .in_d      (in_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Reference: x^(128+k) mod f is built by repeated multiply-by-x in the
    // 128-bit field; the result is in_d plus the sum of those powers selected
    // by the set bits of in_c.
    function automatic logic [127:0] mul_x(input logic [127:0] a);
        return {a[126:0], 1'b0} ^ (a[127] ? POLY : 128'd0);
    endfunction

    function automatic logic [127:0] ref_reduce(input logic [127:0] c, input logic [127:0] d);
        logic [127:0] p;
        logic [127:0] acc;
        p   = POLY;
        acc = d;
        for (int k = 0; k < 128; k++) begin
            if (c[k]) acc = acc ^ p;
            p = mul_x(p);
        end
        return acc;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for out_valid; returns clocks elapsed since the call.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 300) begin
            step();
            lat++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $error("FAIL %s_timeout observed=no_out_valid expected=out_valid", tag);
        end
    endtask

    // Full transaction: accept, wait for result, check it, drain.
    task automatic do_op(input string tag, input logic [127:0] c, input logic [127:0] d,
                         input bit chk_lat);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 300) begin
            step();
            guard++;
        end
        in_valid = 1'b1;
        in_c     = c;
        in_d     = d;
        step();
        in_valid = 1'b0;
        wait_valid(tag, lat);
`ifndef GF_REDUCE_ZERO_SKIP_EN
        if (chk_lat) begin
            checks++;
            assert (lat == LAT) else begin
                failures++;
                $error("FAIL %s_latency observed=%0d expected=%0d", tag, lat, LAT);
            end
        end
`endif
        check128({tag, "_data"}, out_data, ref_reduce(c, d));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check1({tag, "_valid_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [127:0] c;
        logic [127:0] d;
        logic [127:0] hold;
        int lat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_c      = '0;
        in_d      = '0;
        out_ready = 1'b0;
        #12;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check128("rst_out_data", out_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed vectors with hand-derived results.
        do_op("t1_passthru", 128'd0, 128'hDEAD_BEEF, 1'b1);
        check128("t1_const", out_data, 128'hDEAD_BEEF);
        do_op("t2_x128", 128'h1, 128'd0, 1'b1);
        check128("t2_const", out_data, 128'h87);
        do_op("t3_x129", 128'h2, 128'd0, 1'b1);
        check128("t3_const", out_data, 128'h10E);
        do_op("t4_x255", 128'h1 << 127, 128'd0, 1'b1);
        check128("t4_const", out_data, 128'h8000_0000_0000_0000_0000_0000_0000_2049);

        // Back-to-back operands with the result stalled.
        c = rand128();
        d = rand128();
        in_valid = 1'b1;
        in_c = c;
        in_d = d;
        step();
        wait_valid("t5a", lat);
        hold = out_data;
        check128("t5a_data", hold, ref_reduce(c, d));
        in_c = ~c;
        in_d = ~d;
        for (int i = 0; i < 10; i++) begin
            step();
            check1("t5_in_ready_low", in_ready, 1'b0);
            check128("t5_data_stable", out_data, hold);
            check1("t5_valid_held", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check1("t5_release_in_ready", in_ready, 1'b1);
        check1("t5_release_valid", out_valid, 1'b0);
        step();
        check1("t5b_accepted", in_ready, 1'b0);
        in_valid = 1'b0;
        wait_valid("t5b", lat);
        check128("t5b_data", out_data, ref_reduce(~c, ~d));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset in the middle of RUN.
        in_valid = 1'b1;
        in_c = 128'h1 << 127;
        in_d = rand128();
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check1("t6_pre_busy", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check1("t6_abort_valid", out_valid, 1'b0);
        check1("t6_abort_in_ready", in_ready, 1'b1);
        check128("t6_abort_data", out_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_op("t6_after", rand128(), rand128(), 1'b1);

        // Random vectors, including sparse and empty upper halves.
        for (int n = 0; n < 300; n++) begin
            case (n % 4)
                0: c = 128'd0;
                1: c = 128'h1 << $urandom_range(127, 0);
                default: c = rand128();
            endcase
            d = rand128();
            do_op("rand", c, d, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
